// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive FIFO and its storage array.
package uart_rx_fifo_pkg;
    localparam int unsigned DATA_W             = 8;
    localparam int unsigned AW_DEFAULT         = 4;
    localparam int unsigned HIGH_WATER_DEFAULT = 12;
endpackage

// File: rtl/uart_fifo_mem.sv
// 2**AW x DW array: synchronous write, asynchronous read (distributed RAM).
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: byte strobe in, first-word-fall-through
// valid/ready out, occupancy flags and a sticky overflow flag.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned AW         = AW_DEFAULT,
    parameter int unsigned HIGH_WATER = HIGH_WATER_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_new,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic              flush,
    input  logic              clr_ovf,
    output logic [AW:0]       count,
    output logic              full,
    output logic              high_water,
    output logic              overflow
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_req;
    logic          push_req;
    logic          pop;
    logic          push;
    logic          drop;

    assign rd_valid   = (count != '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign high_water = (count >= (AW+1)'(HIGH_WATER));

    // A pop frees the slot, so a push into a full FIFO is accepted alongside it.
    assign pop_req  = rd_valid & rd_ready;
    assign push_req = rx_new & (~full | pop_req);
    assign pop      = pop_req & ~flush;
    assign push     = push_req & ~flush;
    assign drop     = rx_new & ~push_req & ~flush;

    uart_fifo_mem #(
        .AW (AW),
        .DW (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A drop in the same cycle as clr_ovf leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end
endmodule
